// File: rtl/segment_sequencer.sv
// rtl/segment_sequencer.sv - walks a segment ROM, restarts line_drawer per segment and forwards its pixels
// as colour-tagged framebuffer writes; one start pulse draws the whole list.
module segment_sequencer #(
   parameter int NUM_SEGS = 64,
   parameter int AW       = 6,
   parameter int WE_DELAY = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   output logic          busy_o,
   output logic          frame_done_o,
   output logic [AW-1:0] seg_addr_o,
   input  logic [47:0]   seg_data_i,
   output logic          ld_reset_o,
   output logic [10:0]   ld_x0_o,
   output logic [10:0]   ld_y0_o,
   output logic [10:0]   ld_x1_o,
   output logic [10:0]   ld_y1_o,
   input  logic [10:0]   ld_x_i,
   input  logic [10:0]   ld_y_i,
   input  logic          ld_done_i,
   output logic [10:0]   pix_x_o,
   output logic [10:0]   pix_y_o,
   output logic [3:0]    pix_colour_o,
   output logic          pix_we_o
);

   localparam int LAST_SEG_I = (NUM_SEGS > 0) ? NUM_SEGS - 1 : 0;
   localparam int LAST_DLY_I = (WE_DELAY > 0) ? WE_DELAY - 1 : 0;
   localparam int DW         = (WE_DELAY > 1) ? $clog2(WE_DELAY) : 1;

   localparam logic [AW:0]   LAST_SEG = (AW + 1)'(LAST_SEG_I);
   localparam logic [AW:0]   IDX_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] ADDR_ONE = AW'(1);
   localparam logic [DW-1:0] LAST_DLY = DW'(LAST_DLY_I);
   localparam logic [DW-1:0] DLY_ONE  = DW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_SETTLE,
      S_DRAW,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   seg_idx_q, seg_idx_d;
   logic [AW-1:0] seg_addr_q, seg_addr_d;
   logic [DW-1:0] dly_q, dly_d;
   logic          busy_q, busy_d;
   logic          frame_done_q, frame_done_d;
   logic [10:0]   x0_q, x0_d;
   logic [10:0]   y0_q, y0_d;
   logic [10:0]   x1_q, x1_d;
   logic [10:0]   y1_q, y1_d;
   logic [3:0]    colour_q, colour_d;
   logic [10:0]   pix_x_q, pix_x_d;
   logic [10:0]   pix_y_q, pix_y_d;
   logic          pix_we_q, pix_we_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         seg_idx_q    <= '0;
         seg_addr_q   <= '0;
         dly_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         x0_q         <= '0;
         y0_q         <= '0;
         x1_q         <= '0;
         y1_q         <= '0;
         colour_q     <= '0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         seg_idx_q    <= seg_idx_d;
         seg_addr_q   <= seg_addr_d;
         dly_q        <= dly_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         x1_q         <= x1_d;
         y1_q         <= y1_d;
         colour_q     <= colour_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_we_q     <= pix_we_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      seg_idx_d    = seg_idx_q;
      seg_addr_d   = seg_addr_q;
      dly_d        = dly_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      x0_d         = x0_q;
      y0_d         = y0_q;
      x1_d         = x1_q;
      y1_d         = y1_q;
      colour_d     = colour_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_we_d     = 1'b0;
      ld_reset_o   = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               seg_idx_d  = '0;
               seg_addr_d = '0;
               busy_d     = 1'b1;
               state_d    = (NUM_SEGS == 0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            x0_d     = seg_data_i[47:37];
            y0_d     = seg_data_i[36:26];
            x1_d     = seg_data_i[25:15];
            y1_d     = seg_data_i[14:4];
            colour_d = seg_data_i[3:0];
            dly_d    = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            ld_reset_o = 1'b0;
            if (dly_q == LAST_DLY) begin
               state_d = S_DRAW;
            end else begin
               dly_d = dly_q + DLY_ONE;
            end
         end
         S_DRAW: begin
            // The done cycle is not written, so the next segment's colour never meets a stale coordinate.
            ld_reset_o = 1'b0;
            pix_x_d    = ld_x_i;
            pix_y_d    = ld_y_i;
            pix_we_d   = ~ld_done_i;
            if (ld_done_i) begin
               if (seg_idx_q == LAST_SEG) begin
                  state_d = S_DONE;
               end else begin
                  seg_idx_d  = seg_idx_q + IDX_ONE;
                  seg_addr_d = seg_addr_q + ADDR_ONE;
                  state_d    = S_FETCH;
               end
            end
         end
         S_DONE: begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;
   assign seg_addr_o   = seg_addr_q;
   assign ld_x0_o      = x0_q;
   assign ld_y0_o      = y0_q;
   assign ld_x1_o      = x1_q;
   assign ld_y1_o      = y1_q;
   assign pix_x_o      = pix_x_q;
   assign pix_y_o      = pix_y_q;
   assign pix_colour_o = colour_q;
   assign pix_we_o     = pix_we_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// tb/tb_segment_sequencer.sv - directed bench: three sequencers (1, 3 and 0 segments) driving line_drawer stubs.
module tb_segment_sequencer;

   localparam int AW = 2;
   localparam int WD = 6;
   localparam int NI = 3;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic reset;
   logic start [NI];
   logic busy [NI];
   logic frame_done [NI];
   logic pix_we [NI];
   logic ld_reset [NI];
   logic [AW-1:0] seg_addr [NI];
   logic [10:0] pix_x [NI];
   logic [10:0] pix_y [NI];
   logic [3:0] pix_colour [NI];
   logic [47:0] rom [4];

   // Hand-derived pixel lists: shallow, steep, reversed.
   int px [3][8] = '{'{2, 3, 4, 5, 6, 7, 8, 0}, '{6, 7, 7, 8, 8, 9, 9, 0}, '{5, 4, 3, 2, 1, 0, 0, 0}};
   int py [3][8] = '{'{6, 7, 7, 8, 8, 9, 9, 0}, '{2, 3, 4, 5, 6, 7, 8, 0}, '{6, 5, 5, 4, 4, 0, 0, 0}};
   int np [3] = '{7, 7, 5};
   logic [3:0] col [3] = '{4'hA, 4'h5, 4'hC};

   int n_checks = 0;
   int n_errors = 0;

   logic clr_req;
   int wr_cnt [NI];
   int bad [NI];
   int fd_cnt [NI];
   int busy_cnt [NI];
   int col_chg [NI];
   int col_bad [NI];
   int stale [NI];
   int addr_chg [NI];
   int addr_log [NI];
   logic [3:0] last_col [NI] = '{default: '0};
   logic [AW-1:0] last_addr [NI] = '{default: '0};
   bit hit [NI][3][8];

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int NS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
      logic [47:0] sd;
      logic [10:0] x0, y0, x1, y1, lx, ly;
      logic ldn;
      int cyc;
      int s, n, k, idx;

      always @(posedge clk) sd <= rom[seg_addr[g]];
      always @(posedge clk) begin
         if (ld_reset[g]) cyc <= 0;
         else if (cyc < 1000) cyc <= cyc + 1;
      end

      // Drawer stub: WD fill cycles, then each pixel held two cycles, then a done pulse.
      always_comb begin
         s = -1;
         idx = 0;
         for (int i = 0; i < 3; i++)
            if (x0 == 11'(px[i][0]) && y0 == 11'(py[i][0]) &&
                x1 == 11'(px[i][np[i]-1]) && y1 == 11'(py[i][np[i]-1])) s = i;
         n = (s >= 0) ? np[s] : 0;
         k = cyc - WD;
         lx = '0;
         ly = '0;
         if (n > 0) begin
            idx = (k < 0) ? 0 : ((k / 2 < n) ? k / 2 : n - 1);
            lx = 11'(px[s][idx]);
            ly = 11'(py[s][idx]);
         end
         ldn = (k == 2 * n);
      end

      segment_sequencer #(.NUM_SEGS(NS), .AW(AW), .WE_DELAY(WD)) u_dut (
         .clk          (clk),
         .reset        (reset),
         .start_i      (start[g]),
         .busy_o       (busy[g]),
         .frame_done_o (frame_done[g]),
         .seg_addr_o   (seg_addr[g]),
         .seg_data_i   (sd),
         .ld_reset_o   (ld_reset[g]),
         .ld_x0_o      (x0),
         .ld_y0_o      (y0),
         .ld_x1_o      (x1),
         .ld_y1_o      (y1),
         .ld_x_i       (lx),
         .ld_y_i       (ly),
         .ld_done_i    (ldn),
         .pix_x_o      (pix_x[g]),
         .pix_y_o      (pix_y[g]),
         .pix_colour_o (pix_colour[g]),
         .pix_we_o     (pix_we[g])
      );
   end

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (clr_req) begin
            wr_cnt[g] = 0; bad[g] = 0; fd_cnt[g] = 0; busy_cnt[g] = 0; col_chg[g] = 0;
            col_bad[g] = 0; stale[g] = 0; addr_chg[g] = 0; addr_log[g] = 0;
            for (int s = 0; s < 3; s++)
               for (int i = 0; i < 8; i++) hit[g][s][i] = 1'b0;
         end else begin
            if (busy[g]) busy_cnt[g]++;
            if (frame_done[g]) fd_cnt[g]++;
            if (pix_colour[g] != last_col[g]) begin
               col_chg[g]++;
               if (pix_we[g]) col_bad[g]++;
            end
            if (seg_addr[g] != last_addr[g]) begin
               addr_chg[g]++;
               addr_log[g] = (addr_log[g] << 2) | int'(seg_addr[g]);
            end
            if (pix_we[g]) begin
               automatic bit found = 1'b0;
               wr_cnt[g]++;
               for (int s = 0; s < 3; s++)
                  if (pix_colour[g] == col[s])
                     for (int i = 0; i < np[s]; i++)
                        if (pix_x[g] == 11'(px[s][i]) && pix_y[g] == 11'(py[s][i])) begin
                           hit[g][s][i] = 1'b1;
                           found = 1'b1;
                        end
               if (!found) bad[g]++;
               if (pix_x[g] == 11'd8 && pix_y[g] == 11'd9 && pix_colour[g] == 4'h5) stale[g]++;
            end
         end
         last_col[g] = pix_colour[g];
         last_addr[g] = seg_addr[g];
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int hits(input int g, input int s);
      int c = 0;
      for (int i = 0; i < 8; i++) if (hit[g][s][i]) c++;
      return c;
   endfunction

   task automatic clear_stats();
      clr_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 clr_req = 1'b0;
   endtask

   task automatic pulse_start(input int g);
      start[g] = 1'b1;
      @(posedge clk);
      #1 start[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input int budget, input string tag);
      int ok = 0;
      for (int i = 0; i < budget && ok == 0; i++) begin
         @(negedge clk);
         if (frame_done[g]) ok = 1;
      end
      check(tag, ok, 1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_full_frame(input string tag);
      check({tag, "_hits0"}, hits(1, 0), 7);
      check({tag, "_hits1"}, hits(1, 1), 7);
      check({tag, "_hits2"}, hits(1, 2), 5);
      check({tag, "_bad"}, bad[1], 0);
      check({tag, "_writes"}, wr_cnt[1], 38);
      check({tag, "_frame_done"}, fd_cnt[1], 1);
      check({tag, "_busy_cycles"}, busy_cnt[1], 66);
   endtask

   initial begin
      reset = 1'b1;
      clr_req = 1'b1;
      for (int g = 0; g < NI; g++) start[g] = 1'b0;
      for (int s = 0; s < 3; s++)
         rom[s] = {11'(px[s][0]), 11'(py[s][0]), 11'(px[s][np[s]-1]), 11'(py[s][np[s]-1]), col[s]};
      rom[3] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy[1], 0);
      check("rst_frame_done", frame_done[1], 0);
      check("rst_pix_we", pix_we[1], 0);
      check("rst_ld_reset", ld_reset[1], 1);
      check("rst_seg_addr", seg_addr[1], 0);
      check("rst_ld_x0", g_inst[1].x0, 0);
      check("rst_pix_x", pix_x[1], 0);
      check("rst_pix_colour", pix_colour[1], 0);
      reset = 1'b0;
      clr_req = 1'b0;
      @(posedge clk);
      #1;

      // T1 single segment
      clear_stats();
      pulse_start(0);
      wait_done(0, 200, "t1_timeout");
      check("t1_hits", hits(0, 0), 7);
      check("t1_bad", bad[0], 0);
      check("t1_writes", wr_cnt[0], 14);
      check("t1_frame_done", fd_cnt[0], 1);
      check("t1_busy_cycles", busy_cnt[0], 24);
      check("t1_busy_after", busy[0], 0);

      // T2/T3 three segments
      clear_stats();
      pulse_start(1);
      wait_done(1, 400, "t2_timeout");
      check_full_frame("t2");
      check("t2_colour_changes", col_chg[1], 3);
      check("t2_colour_during_we", col_bad[1], 0);
      check("t2_addr_changes", addr_chg[1], 2);
      check("t2_addr_seq", addr_log[1], 6);
      check("t3_stale_pixel", stale[1], 0);

      // T4 start while busy
      clear_stats();
      pulse_start(1);
      repeat (40) @(posedge clk);
      #1;
      check("t4_busy_mid", busy[1], 1);
      pulse_start(1);
      wait_done(1, 400, "t4_timeout");
      repeat (30) @(posedge clk);
      #1;
      check_full_frame("t4");
      check("t4_busy_after", busy[1], 0);

      // T5 reset during segment 1
      clear_stats();
      pulse_start(1);
      begin
         int ok = 0;
         for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (pix_we[1] && pix_colour[1] == 4'h5) ok = 1;
         end
         check("t5_reach_seg1", ok, 1);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("t5_pix_we", pix_we[1], 0);
      check("t5_busy", busy[1], 0);
      check("t5_ld_reset", ld_reset[1], 1);
      check("t5_seg_addr", seg_addr[1], 0);
      reset = 1'b0;
      clear_stats();
      repeat (10) @(posedge clk);
      #1;
      check("t5_no_writes", wr_cnt[1], 0);
      clear_stats();
      pulse_start(1);
      wait_done(1, 400, "t5_timeout");
      check_full_frame("t5");

      // start coinciding with reset is ignored
      reset = 1'b1;
      start[1] = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      start[1] = 1'b0;
      @(posedge clk);
      #1;
      check("rst_start_ignored", busy[1], 0);

      // T6 empty list
      clear_stats();
      start[2] = 1'b1;
      @(posedge clk);
      #1 start[2] = 1'b0;
      check("t6_busy_c1", busy[2], 1);
      check("t6_frame_done_c1", frame_done[2], 0);
      @(posedge clk);
      #1;
      check("t6_frame_done_c2", frame_done[2], 1);
      check("t6_busy_c2", busy[2], 0);
      @(posedge clk);
      #1;
      check("t6_frame_done_c3", frame_done[2], 0);
      repeat (5) @(posedge clk);
      #1;
      check("t6_writes", wr_cnt[2], 0);
      check("t6_addr_changes", addr_chg[2], 0);
      check("t6_frame_done_count", fd_cnt[2], 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
